// File: rtl/clk_div_mc.sv
// clk_div_mc: multi-channel programmable clock-enable generator.
// Each channel divides clk by its own runtime divisor. It outputs either a
// one-cycle strobe (mode=0) or a near-50% square wave (mode=1).
// Divisor changes take effect only at period boundaries, when the channel is
// disabled, or on a global sync.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   en       - per-channel enable
//   mode     - per-channel output mode (0 pulse, 1 square)
//   div      - packed divisors, channel i uses div[i*W +: W]
//   sync     - one-cycle global restart of all channels
//   clk_n    - divided outputs (registered)
//   div_err  - channel enabled with an active divisor < 2 (registered)
module clk_div_mc #(
  parameter int unsigned CH = 4,
  parameter int unsigned W  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   mode,
  input  logic [CH*W-1:0] div,
  input  logic            sync,
  output logic [CH-1:0]   clk_n,
  output logic [CH-1:0]   div_err
);

  logic [W-1:0]  cnt_q [CH];
  logic [W-1:0]  cnt_d [CH];
  logic [W-1:0]  n_q   [CH];
  logic [W-1:0]  n_d   [CH];
  logic [CH-1:0] clk_n_q, clk_n_d;
  logic [CH-1:0] div_err_q, div_err_d;

  // Scratch values per channel
  logic [W-1:0]  div_ch [CH];
  logic [W-1:0]  cnt_nx [CH];
  logic [CH-1:0] wrap;

  // Next-state for every channel
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      n_d[i]       = n_q[i];
      clk_n_d[i]   = 1'b0;
      div_err_d[i] = 1'b0;
      div_ch[i]    = div[i*W +: W];
      wrap[i]      = (cnt_q[i] == (n_q[i] - W'(1)));
      cnt_nx[i]    = wrap[i] ? W'(0) : (cnt_q[i] + W'(1));

      if (sync) begin
        // Global restart: reload shadow, clear phase
        n_d[i]   = div_ch[i];
        cnt_d[i] = W'(0);
      end else if (!en[i]) begin
        // Disabled channel tracks div so enable starts from the new value
        n_d[i]   = div_ch[i];
        cnt_d[i] = W'(0);
      end else if (n_q[i] < W'(2)) begin
        // Invalid divisor: park and flag until the next sync or disable
        cnt_d[i]     = W'(0);
        div_err_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_nx[i];
        if (wrap[i]) n_d[i] = div_ch[i];
        // Output uses the divisor of the period just counted
        if (mode[i]) clk_n_d[i] = (cnt_nx[i] >= (n_q[i] - (n_q[i] >> 1)));
        else         clk_n_d[i] = (cnt_nx[i] == (n_q[i] - W'(1)));
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= W'(0);
        n_q[i]   <= W'(0);
      end
      clk_n_q   <= '0;
      div_err_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        n_q[i]   <= n_d[i];
      end
      clk_n_q   <= clk_n_d;
      div_err_q <= div_err_d;
    end
  end

  assign clk_n   = clk_n_q;
  assign div_err = div_err_q;

endmodule

// File: tb/tb_clk_div_mc.sv
// Testbench for clk_div_mc: directed stimulus with hand-computed expected
// output bits queued per clock edge; a monitor pops and compares them.
module tb_clk_div_mc;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 10;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   en;
  logic [CH-1:0]   mode;
  logic [CH*W-1:0] div;
  logic            sync;
  logic [CH-1:0]   clk_n;
  logic [CH-1:0]   div_err;

  clk_div_mc #(.CH(CH), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .div     (div),
    .sync    (sync),
    .clk_n   (clk_n),
    .div_err (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    ch;
    bit    is_err;
    logic  val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic act;

  // Monitor: every edge, compare all expectations tagged with this edge
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = sb[i].is_err ? div_err[sb[i].ch] : clk_n[sb[i].ch];
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s ch%0d %s edge %0d got %b want %b", sb[i].name,
                   sb[i].ch, sb[i].is_err ? "div_err" : "clk_n", cyc, act,
                   sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int ch, input int rel, input bit is_err,
                      input logic val, input string name);
    exp_t e;
    e.cyc = cyc + rel; e.ch = ch; e.is_err = is_err; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  // Character k of pat is the expected clk_n after edge k+1 from now
  task automatic exp_str(input int ch, input string pat, input string name);
    for (int i = 0; i < pat.len(); i++)
      push(ch, i + 1, 1'b0, (pat.getc(i) == "1") ? 1'b1 : 1'b0, name);
  endtask

  task automatic set_div(input int ch, input int v);
    div[ch*W +: W] = W'(v);
  endtask

  task automatic chk(input string name, input logic [CH-1:0] a,
                     input logic [CH-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %b want %b", name, a, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = '0; mode = '0; div = '0; sync = 1'b0;
    tick(2);
    chk("reset_clk_n", clk_n, 4'b0000);
    chk("reset_div_err", div_err, 4'b0000);
    rst_n = 1'b1;

    // Reset mid-count: ch0 n=5, reset while the strobe is high
    set_div(0, 5); tick(1);
    en[0] = 1'b1;
    exp_str(0, "000100001", "rst_run");
    tick(9);
    rst_n = 1'b0; #1;
    chk("async_rst_clk_n", clk_n, 4'b0000);
    chk("async_rst_div_err", div_err, 4'b0000);
    en = '0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    en[0] = 1'b1;
    exp_str(0, "0001", "rst_release");
    tick(4);
    en[0] = 1'b0;
    push(0, 1, 1'b0, 1'b0, "en_off_latency");
    tick(1);

    // Pulse mode: n=1000, 3, 2, and the maximum 1023
    set_div(0, 1000); set_div(1, 3); set_div(2, 2); set_div(3, 1023);
    tick(1);
    en = 4'b1111;
    push(0, 998, 1'b0, 1'b0, "p1000");
    push(0, 999, 1'b0, 1'b1, "p1000_first");
    push(0, 1000, 1'b0, 1'b0, "p1000_width");
    push(0, 1999, 1'b0, 1'b1, "p1000_period");
    exp_str(1, "01001001", "p3");
    exp_str(2, "1010", "p2");
    push(3, 1021, 1'b0, 1'b0, "p1023");
    push(3, 1022, 1'b0, 1'b1, "p1023_first");
    push(3, 1023, 1'b0, 1'b0, "p1023_width");
    push(3, 2045, 1'b0, 1'b1, "p1023_period");
    tick(2050);
    en = '0; tick(1);

    // Square mode: n=4, 5, 2
    mode = 4'b1111;
    set_div(0, 4); set_div(1, 5); set_div(3, 2);
    tick(1);
    en = 4'b1011;
    exp_str(0, "01100110", "sq4");
    exp_str(1, "0011000110", "sq5");
    exp_str(3, "1010", "sq2");
    tick(10);
    en = '0; tick(1);

    // Glitch-free update: ch2 10 -> 4 written at cnt=3
    mode = '0;
    set_div(2, 10); tick(1);
    en = 4'b0100;
    tick(3);
    set_div(2, 4);
    exp_str(2, "00000100010001", "div_update");
    tick(14);
    en = '0; tick(1);

    // Sync: ch0 n=6 and ch1 n=9 at unrelated phases
    set_div(0, 6); set_div(1, 9); tick(1);
    en = 4'b0001; tick(4);
    en = 4'b0011; tick(3);
    sync = 1'b1;
    exp_str(0, "000001000001000001000001000001000001", "sync6");
    exp_str(1, "000000001000000001000000001000000001", "sync9");
    tick(1);
    sync = 1'b0;
    tick(35);
    en = '0; tick(1);

    // Invalid divisors 0 and 1, then recovery via sync with 7
    set_div(1, 0); tick(1);
    en = 4'b0010;
    push(1, 1, 1'b1, 1'b1, "err_div0");
    push(1, 1, 1'b0, 1'b0, "err_div0_out");
    tick(2);
    en = '0; set_div(1, 1);
    push(1, 1, 1'b1, 1'b0, "err_clear_disabled");
    tick(1);
    en = 4'b0010;
    push(1, 1, 1'b1, 1'b1, "err_div1");
    push(1, 2, 1'b0, 1'b0, "err_div1_out");
    tick(3);
    set_div(1, 7); sync = 1'b1;
    push(1, 1, 1'b1, 1'b0, "err_sync_clear");
    push(1, 2, 1'b1, 1'b0, "err_stays_clear");
    exp_str(1, "00000010000001", "recover7");
    tick(1);
    sync = 1'b0;
    tick(16);

    for (int i = 0; i < sb.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (edge %0d)", sb[i].name, sb[i].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
